// File: rtl/stack_sequencer.sv
// stack_sequencer: call/return sequencer that manages an external stack RAM.
// A call pushes a return address, a return pops one and presents it on
// ret_addr, and every completed operation ends with a single fetch strobe.
// Overflow and underflow attempts are refused and recorded in sticky flags.
module stack_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_call,
  input  logic [DW-1:0] req_addr,
  output logic          req_ready,
  output logic          stk_en,
  output logic          stk_rw,
  output logic [AW-1:0] stk_addr,
  output logic [DW-1:0] stk_wdata,
  input  logic [DW-1:0] stk_rdata,
  output logic          ret_valid,
  output logic [DW-1:0] ret_addr,
  output logic          decode,
  output logic          fetch,
  output logic [AW:0]   sp,
  output logic          full,
  output logic          empty,
  output logic          err_ovf,
  output logic          err_unf,
  input  logic          err_clr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CALL   = 3'd1;
  localparam logic [2:0] S_RET_RD = 3'd2;
  localparam logic [2:0] S_RET_WB = 3'd3;
  localparam logic [2:0] S_FETCH  = 3'd4;

  // Occupancy is one bit wider than the RAM address so that DEPTH itself
  // is representable and "full" never aliases with "empty".
  localparam logic [AW:0]   SP_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic [AW:0]   r_sp;
  logic [DW-1:0] r_op_addr;
  logic          r_is_ret;
  logic [DW-1:0] r_ret_addr;
  logic          r_err_ovf;
  logic          r_err_unf;

  logic          w_idle;
  logic          w_accept;
  logic          w_full;
  logic          w_empty;
  logic          w_ovf_det;
  logic          w_unf_det;
  logic [AW-1:0] w_rd_addr;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = req_valid & w_idle;
  assign w_full    = (r_sp == SP_FULL);
  assign w_empty   = (r_sp == '0);
  assign w_ovf_det = w_accept &  req_call &  w_full;
  assign w_unf_det = w_accept & ~req_call &  w_empty;
  // When sp equals DEPTH the low bits are zero and the subtraction wraps to
  // DEPTH-1, which is exactly the top entry.
  assign w_rd_addr = r_sp[AW-1:0] - ADDR_ONE;

  // Next-state selection; refused pushes/pops keep the FSM parked in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_call && !w_full) begin
            w_next_state = S_CALL;
          end else if (!req_call && !w_empty) begin
            w_next_state = S_RET_RD;
          end
        end
      end
      S_CALL:   w_next_state = S_FETCH;
      S_RET_RD: w_next_state = S_RET_WB;
      S_RET_WB: w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stack pointer moves only in the cycle the RAM is actually accessed,
  // and the full/empty guards keep it inside 0..DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (r_state == S_CALL && !w_full) begin
      r_sp <= r_sp + SP_ONE;
    end else if (r_state == S_RET_RD && !w_empty) begin
      r_sp <= r_sp - SP_ONE;
    end
  end

  // Capture the request address and operation type at the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_addr <= '0;
      r_is_ret  <= 1'b0;
    end else if (w_accept) begin
      r_op_addr <= req_addr;
      r_is_ret  <= ~req_call;
    end
  end

  // Popped address arrives from the RAM one cycle after the read enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_addr <= '0;
    end else if (r_state == S_RET_WB) begin
      r_ret_addr <= stk_rdata;
    end
  end

  // Sticky error flags; a freshly detected error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_err_ovf <= w_ovf_det | (r_err_ovf & ~err_clr);
      r_err_unf <= w_unf_det | (r_err_unf & ~err_clr);
    end
  end

  // Output decode is purely from state, so reset clears it immediately.
  always_comb begin
    req_ready = 1'b0;
    decode    = 1'b0;
    fetch     = 1'b0;
    ret_valid = 1'b0;
    stk_en    = 1'b0;
    stk_rw    = 1'b0;
    stk_addr  = '0;
    stk_wdata = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        decode    = 1'b1;
      end
      S_CALL: begin
        stk_en    = 1'b1;
        stk_rw    = 1'b1;
        stk_addr  = r_sp[AW-1:0];
        stk_wdata = r_op_addr;
      end
      S_RET_RD: begin
        stk_en    = 1'b1;
        stk_addr  = w_rd_addr;
      end
      S_FETCH: begin
        fetch     = 1'b1;
        ret_valid = r_is_ret;
      end
      default: begin
        fetch     = 1'b0;
      end
    endcase
  end

  assign sp       = r_sp;
  assign full     = w_full;
  assign empty    = w_empty;
  assign err_ovf  = r_err_ovf;
  assign err_unf  = r_err_unf;
  assign ret_addr = r_ret_addr;

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: randomized scoreboard bench for stack_sequencer with a
// behavioural stack RAM and a queue-based reference stack.
module tb_stack_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_call;
  logic [DW-1:0] req_addr;
  logic          req_ready;
  logic          stk_en;
  logic          stk_rw;
  logic [AW-1:0] stk_addr;
  logic [DW-1:0] stk_wdata;
  logic [DW-1:0] stk_rdata;
  logic          ret_valid;
  logic [DW-1:0] ret_addr;
  logic          decode;
  logic          fetch;
  logic [AW:0]   sp;
  logic          full;
  logic          empty;
  logic          err_ovf;
  logic          err_unf;
  logic          err_clr;

  stack_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_call(req_call), .req_addr(req_addr),
    .req_ready(req_ready),
    .stk_en(stk_en), .stk_rw(stk_rw), .stk_addr(stk_addr),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .ret_valid(ret_valid), .ret_addr(ret_addr),
    .decode(decode), .fetch(fetch), .sp(sp),
    .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr)
  );

  typedef struct {
    bit            isRet;
    logic [DW-1:0] addr;
    int            expSp;
    int            cycle;
  } fetchExp_t;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } writeExp_t;

  fetchExp_t     expQ[$];
  writeExp_t     writeQ[$];
  int            readQ[$];
  logic [DW-1:0] modelStack[$];
  bit            modelOvf;
  bit            modelUnf;

  logic [DW-1:0] ram [DEPTH];
  int            compared = 0;
  int            mismatched = 0;
  int            cycleCount = 0;
  bit            opIsCall;
  bit            opClr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural stack RAM: synchronous write, registered read data.
  always @(posedge clk) begin
    if (stk_en && stk_rw) begin
      ram[stk_addr] <= stk_wdata;
    end else if (stk_en) begin
      stk_rdata <= ram[stk_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportUnexpected(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got unexpected event, expected none at %0t", name, $time);
  endtask

  // Monitor: pops expected RAM accesses and fetch responses as they appear.
  always @(negedge clk) begin
    writeExp_t w;
    fetchExp_t e;
    int        ra;
    if (rst_n) begin
      if (stk_en && stk_rw) begin
        if (writeQ.size() == 0) begin
          reportUnexpected("ramWrite");
        end else begin
          w = writeQ.pop_front();
          checkOutput("wrAddr", 32'(stk_addr), 32'(w.addr));
          checkOutput("wrData", 32'(stk_wdata), 32'(w.data));
        end
      end else if (stk_en) begin
        if (readQ.size() == 0) begin
          reportUnexpected("ramRead");
        end else begin
          ra = readQ.pop_front();
          checkOutput("rdAddr", 32'(stk_addr), 32'(ra));
          checkOutput("rdWdata", 32'(stk_wdata), 0);
        end
      end
      if (fetch) begin
        if (expQ.size() == 0) begin
          reportUnexpected("fetch");
        end else begin
          e = expQ.pop_front();
          checkOutput("fetchCycle", cycleCount, e.cycle);
          checkOutput("retValid", 32'(ret_valid), 32'(e.isRet));
          if (e.isRet) checkOutput("retAddr", 32'(ret_addr), 32'(e.addr));
          checkOutput("fetchSp", 32'(sp), e.expSp);
          checkOutput("fetchStkEn", 32'(stk_en), 0);
          checkOutput("fetchDecode", 32'(decode), 0);
        end
      end else if (ret_valid) begin
        reportUnexpected("retValidNoFetch");
      end
    end
  end

  // Issue one request, update the reference stack and queue expectations.
  task automatic applyStimulus(input bit isCall, input logic [DW-1:0] addr, input bit clr);
    int guard = 0;
    int size;
    fetchExp_t e;
    writeExp_t w;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      reportUnexpected("readyTimeout");
      return;
    end
    req_valid = 1'b1;
    req_call  = isCall;
    req_addr  = addr;
    err_clr   = clr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    err_clr   = 1'b0;
    req_call  = 1'($urandom);
    req_addr  = DW'($urandom);
    size = modelStack.size();
    if (clr) begin
      modelOvf = 1'b0;
      modelUnf = 1'b0;
    end
    if (isCall) begin
      if (size == DEPTH) begin
        modelOvf = 1'b1;
      end else begin
        w.addr = size;
        w.data = addr;
        writeQ.push_back(w);
        e.isRet = 1'b0;
        e.addr  = '0;
        e.expSp = size + 1;
        e.cycle = cycleCount + 1;
        expQ.push_back(e);
        modelStack.push_back(addr);
      end
    end else begin
      if (size == 0) begin
        modelUnf = 1'b1;
      end else begin
        readQ.push_back(size - 1);
        e.isRet = 1'b1;
        e.addr  = modelStack[size-1];
        e.expSp = size - 1;
        e.cycle = cycleCount + 2;
        expQ.push_back(e);
        void'(modelStack.pop_back());
      end
    end
    checkOutput("spAtAccept", 32'(sp), size);
    checkOutput("errOvf", 32'(err_ovf), 32'(modelOvf));
    checkOutput("errUnf", 32'(err_unf), 32'(modelUnf));
    checkOutput("readyAfterAccept", 32'(req_ready), isCall ? 32'(size == DEPTH) : 32'(size == 0));
    checkOutput("fullFlag", 32'(full), 32'(size == DEPTH));
    checkOutput("emptyFlag", 32'(empty), 32'(size == 0));
  endtask

  // Assert reset asynchronously, check the cleared outputs, then release.
  task automatic resetDut();
    rst_n = 1'b0;
    expQ.delete();
    writeQ.delete();
    readQ.delete();
    modelStack.delete();
    modelOvf = 1'b0;
    modelUnf = 1'b0;
    #1;
    checkOutput("rstSp", 32'(sp), 0);
    checkOutput("rstStkEn", 32'(stk_en), 0);
    checkOutput("rstStkAddr", 32'(stk_addr), 0);
    checkOutput("rstFetch", 32'(fetch), 0);
    checkOutput("rstRetValid", 32'(ret_valid), 0);
    checkOutput("rstRetAddr", 32'(ret_addr), 0);
    checkOutput("rstErrOvf", 32'(err_ovf), 0);
    checkOutput("rstErrUnf", 32'(err_unf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("releaseReady", 32'(req_ready), 1);
    checkOutput("releaseDecode", 32'(decode), 1);
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    stk_rdata = '0;
    req_valid = 1'b0;
    req_call  = 1'b0;
    req_addr  = '0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    #12;
    resetDut();

    // First call after reset writes entry 0 and finishes with a fetch.
    applyStimulus(1'b1, 8'h3A, 1'b0);
    checkOutput("callStkEn", 32'(stk_en), 1);
    checkOutput("callStkRw", 32'(stk_rw), 1);
    checkOutput("callStkAddr", 32'(stk_addr), 0);
    checkOutput("callWdata", 32'(stk_wdata), 32'h3A);
    drain();
    checkOutput("spAfterCall", 32'(sp), 1);

    // Two pushes followed by two pops come back in LIFO order.
    resetDut();
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain();
    checkOutput("spAfterLifo", 32'(sp), 0);

    // Pop from an empty stack is refused and flagged.
    applyStimulus(1'b0, 8'h55, 1'b0);
    drain();
    checkOutput("unfSticky", 32'(err_unf), 1);

    // Fill to DEPTH, then overflow, then overflow with a same-cycle clear.
    resetDut();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    applyStimulus(1'b1, 8'hEF, 1'b1);
    drain();
    checkOutput("ovfSp", 32'(sp), DEPTH);
    checkOutput("ovfSticky", 32'(err_ovf), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    drain();

    // Reset in the middle of a pop abandons it.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(8'h40 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("retRdStkEn", 32'(stk_en), 1);
    checkOutput("retRdAddr", 32'(stk_addr), 2);
    resetDut();
    drain();

    // Randomized phases alternating between push-heavy and pop-heavy.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 40; i++) begin
        opIsCall = ($urandom_range(0, 99) < ((p % 2 == 0) ? 75 : 25));
        opClr    = ($urandom_range(0, 9) == 0);
        applyStimulus(opIsCall, DW'($urandom), opClr);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end
    drain();
    checkOutput("finalSp", 32'(sp), modelStack.size());
    checkOutput("expQDrained", expQ.size(), 0);
    checkOutput("writeQDrained", writeQ.size(), 0);
    checkOutput("readQDrained", readQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: number of stack entries, a power of two from 2 to 256.
REQ-002 Parameter AW, default 4: stack RAM address width, equal to log2(DEPTH).
REQ-003 Parameter DW, default 8: return-address width.
REQ-004 clk  in  1  Single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  Asynchronous, active-low reset.
REQ-006 req_valid  in  1  Requester has a call or return pending.
REQ-007 req_call  in  1  Request type: 1 = call (push), 0 = return (pop); qualified by req_valid.
REQ-008 req_addr  in  DW  Return address to push on a call; ignored on a return.
REQ-009 req_ready  out  1  Sequencer accepts the request this cycle.
REQ-010 stk_en  out  1  Stack RAM enable.
REQ-011 stk_rw  out  1  Stack RAM direction: 1 = write, 0 = read.
REQ-012 stk_addr  out  AW  Stack RAM address.
REQ-013 stk_wdata  out  DW  Stack RAM write data.
REQ-014 stk_rdata  in  DW  Stack RAM read data; valid one cycle after a read enable.
REQ-015 ret_valid  out  1  One-cycle pulse; ret_addr holds a popped address.
REQ-016 ret_addr  out  DW  Last popped return address.
REQ-017 decode  out  1  Decode-phase strobe.
REQ-018 fetch  out  1  Fetch-phase strobe.
REQ-019 sp  out  AW+1  Occupancy: number of valid entries, 0 to DEPTH.
REQ-020 full / empty  out  1 each  full = (sp == DEPTH); empty = (sp == 0).
REQ-021 err_ovf / err_unf  out  1 each  Sticky overflow and underflow flags.
REQ-022 err_clr  in  1  Synchronous clear of both error flags.

Function
REQ-023 The FSM SHALL have five states: IDLE, CALL, RET_RD, RET_WB and FETCH.
REQ-024 IDLE: req_ready = 1 and decode = 1; every other state drives req_ready = 0 and decode = 0.
REQ-025 A request is accepted only when req_valid and req_ready are both 1 on a rising edge; req_addr is latched at that edge.
REQ-026 IDLE, accepted call with !full: next state CALL.
REQ-027 IDLE, accepted call with full: err_ovf is set, sp is unchanged, no RAM access occurs, and the FSM stays in IDLE.
REQ-028 IDLE, accepted return with !empty: next state RET_RD.
REQ-029 IDLE, accepted return with empty: err_unf is set, sp is unchanged, no RAM access occurs, and the FSM stays in IDLE.
REQ-030 CALL: stk_en = 1, stk_rw = 1, stk_addr = sp[AW-1:0], stk_wdata = latched req_addr; sp increments by 1 at the end of the cycle; next state FETCH.
REQ-031 RET_RD: stk_en = 1, stk_rw = 0, stk_addr = sp - 1; sp decrements by 1 at the end of the cycle; next state RET_WB.
REQ-032 RET_WB: stk_en = 0; ret_addr loads stk_rdata at the end of the cycle; next state FETCH.
REQ-033 FETCH: fetch = 1 for exactly one cycle; ret_valid = 1 only if the current operation is a return; next state IDLE.
REQ-034 Outside CALL and RET_RD: stk_en = 0, stk_rw = 0, stk_addr = 0, stk_wdata = 0.
REQ-035 Latency from acceptance edge to fetch: a call shows CALL then FETCH (fetch in the 2nd cycle after acceptance); a return shows RET_RD, RET_WB, FETCH (fetch in the 3rd cycle).
REQ-036 Throughput: a new request may be accepted in the first IDLE cycle after FETCH, giving a minimum spacing of 3 cycles for calls and 4 cycles for returns.
REQ-037 sp never wraps; it stays within 0 to DEPTH under all input sequences.
REQ-038 If err_clr is asserted in the same cycle that a new error is detected, the set wins.
REQ-039 err_clr has no effect on the FSM, sp or ret_addr.
REQ-040 req_valid and req_call are don't-care outside IDLE.

Reset
REQ-041 While rst_n = 0, regardless of clk: state = IDLE, sp = 0, ret_addr = 0, err_ovf = 0, err_unf = 0, ret_valid = 0, fetch = 0, all stk_* outputs = 0.
REQ-042 Reset asserted mid-operation (CALL, RET_RD or RET_WB) abandons the operation; no further RAM access or strobe is issued.
REQ-043 After reset release, IDLE outputs (decode = 1, req_ready = 1) appear immediately.
REQ-044 Stack RAM contents are outside this block and are not cleared by reset.

Verification
REQ-045 Reset release, then call with req_addr = 0x3A: CALL cycle shows stk_en = 1, stk_rw = 1, stk_addr = 0, stk_wdata = 0x3A; next cycle fetch = 1, ret_valid = 0; sp = 1.
REQ-046 Calls of 0x11, 0x22, then two returns (behavioural RAM model): ret_addr = 0x22 then 0x11, each with ret_valid = 1 coincident with fetch; sp ends at 0.
REQ-047 Return while empty: err_unf = 1, sp = 0, stk_en never asserted, FSM back in IDLE the next cycle.
REQ-048 DEPTH = 16 calls then a 17th call: err_ovf = 1, sp = 16, no write; err_clr and the 17th call asserted together: err_ovf stays 1.
REQ-049 rst_n pulsed low during RET_RD with sp = 3: outputs clear asynchronously, sp = 0, and no ret_valid or fetch follows.
